hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised pipeline hazard controller for the RV32I core. It sits beside the ID stage and tracks the destination registers of in-flight instructions in a shift-register scoreboard of configurable depth. From that state it raises RAW stalls, with optional forwarding-aware load-use-only mode, and control-flow flushes. It also keeps saturating stall/flush event counters for performance analysis.

## Interface
- REG_ADDR_WIDTH, 5: register index width.
- TRACK_DEPTH, 3: number of downstream stages tracked; slot 0 = EX, slot TRACK_DEPTH-1 = oldest (WB). Legal 1..8.
- FORWARDING, 0: 0 = stall on any tracked match; 1 = stall only on load-use (load in slot 0).
- CNT_WIDTH, 16: width of event counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low (0 = reset).
- ID_valid  input  1  ID holds a real instruction.
- ID_rs1, ID_rs2  input  REG_ADDR_WIDTH  source indices.
- ID_rs1_used, ID_rs2_used  input  1  source actually read.
- ID_rd  input  REG_ADDR_WIDTH  destination index.
- ID_rd_write  input  1  instruction writes rd.
- ID_is_load  input  1  instruction is a load.
- branch_prediction_miss  input  1  EX-resolved mispredict.
- EX_jump  input  1  EX-resolved jump.
- hazard_op  output  1  stall PC and IF/ID; insert bubble into ID/EX.
- IF_ID_flush  output  1  squash IF/ID register.
- ID_EX_flush  output  1  squash ID/EX register (bubble).
- stall_count  output  CNT_WIDTH  cycles with hazard_op=1, saturating.
- flush_count  output  CNT_WIDTH  cycles with IF_ID_flush=1, saturating.

## Operation
- Scoreboard: TRACK_DEPTH slots {valid, rd, is_load}; shifts toward the oldest slot every cycle, with no hold. The oldest entry drops out.
- Slot 0 load rule: ID instruction when ID_valid & ~hazard_op & ~flush, with valid = ID_rd_write & (ID_rd != 0). Otherwise a bubble (valid=0) is loaded.
- Match k for source s: s_used & slot[k].valid & (slot[k].rd == s). x0 never matches because x0 is never loaded valid.
- raw = ID_valid & (FORWARDING ? (match on slot 0 & slot[0].is_load) : (any match over all slots)).
- flush = branch_prediction_miss | EX_jump.
- IF_ID_flush = flush; ID_EX_flush = flush | raw; hazard_op = raw & ~flush. Flush overrides stall.
- The EX instruction causing the flush is already in slot 0 and stays valid, so a JAL/JALR link register is still tracked.
- Counters increment by 1 per qualifying cycle and saturate at all-ones; no wrap.
- All decode outputs are combinational from current inputs and scoreboard state. There is no output register.

## Timing
- Reset (reset=0, asynchronous): all slots invalid, counters 0. With ID_valid=0 all flag outputs are 0. The first clk edge after release is a normal shift.
- Reset asserted mid-stall or mid-flush clears the scoreboard immediately; hazard_op falls in the same cycle.
- FORWARDING=0, dependent instruction directly after producer: hazard_op=1 for exactly TRACK_DEPTH cycles. With a gap of g independent instructions: TRACK_DEPTH-g cycles, floored at 0.
- FORWARDING=1, load followed immediately by dependent instruction: 1 stall cycle. Non-load producer: 0 cycles.
- During a stall the ID inputs are held by the pipeline. Bubbles advance the producer until no match remains.
- Simultaneous stall and flush: hazard_op=0, IF_ID_flush=1, ID_EX_flush=1, stall_count unchanged, flush_count +1.
- Both flush sources high in one cycle count once.

## Test plan
- Reset: hold reset=0 with arbitrary inputs. Expect counters=0 and hazard_op=0. Release; issue x1/x2 -> x3: no hazard.
- Default params, no forwarding: issue rd=3, then rs1=3 held. Expect hazard_op=1 for 3 cycles, then 0, and stall_count=3.
- rs2 match with rs2_used=0: producer rd=5, consumer rs2=5 unused. Expect hazard_op=0. Producer rd=0, consumer rs1=0: expect hazard_op=0.
- FORWARDING=1: load rd=7 followed by rs1=7. Expect 1 stall cycle. ALU producer rd=7 followed by rs1=7: expect 0 stall cycles.
- Stall plus branch_prediction_miss in the same cycle: expect hazard_op=0, IF_ID_flush=1, ID_EX_flush=1, flush_count=1. EX_jump one cycle later: flush_count=2.
- CNT_WIDTH=2: force 5 stall cycles. Expect stall_count=3 (saturated). Assert reset mid-stall: counters 0 and hazard_op 0 immediately.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks destinations of in-flight instructions in a
// shift-register scoreboard beside ID and decodes RAW stalls (full or
// load-use-only) plus control-flow flushes, with saturating event counters.
module hazard_scoreboard #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int TRACK_DEPTH    = 3,
   parameter int FORWARDING     = 0,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ID_valid,
   input  logic [REG_ADDR_WIDTH-1:0] ID_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] ID_rs2,
   input  logic                      ID_rs1_used,
   input  logic                      ID_rs2_used,
   input  logic [REG_ADDR_WIDTH-1:0] ID_rd,
   input  logic                      ID_rd_write,
   input  logic                      ID_is_load,
   input  logic                      branch_prediction_miss,
   input  logic                      EX_jump,
   output logic                      hazard_op,
   output logic                      IF_ID_flush,
   output logic                      ID_EX_flush,
   output logic [CNT_WIDTH-1:0]      stall_count,
   output logic [CNT_WIDTH-1:0]      flush_count
);

   // With forwarding only a load sitting in EX cannot be bypassed in time.
   localparam bit FWD_EN = (FORWARDING != 0);

   // Saturating increment: counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (&v) begin
         return v;
      end
      return v + CNT_WIDTH'(1);
   endfunction

   // Scoreboard slots: index 0 is EX, TRACK_DEPTH-1 is the oldest tracked stage.
   logic [TRACK_DEPTH-1:0]    vld_q, vld_d;
   logic [TRACK_DEPTH-1:0]    ld_q, ld_d;
   logic [REG_ADDR_WIDTH-1:0] rd_q [TRACK_DEPTH];
   logic [REG_ADDR_WIDTH-1:0] rd_d [TRACK_DEPTH];

   logic [TRACK_DEPTH-1:0]    hit_rs1, hit_rs2, hit;
   logic                      flush, raw, issue;

   logic [CNT_WIDTH-1:0]      stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0]      flush_cnt_q, flush_cnt_d;

   // Compare each used ID source against every valid tracked destination.
   always_comb begin
      hit_rs1 = '0;
      hit_rs2 = '0;
      for (int k = 0; k < TRACK_DEPTH; k++) begin
         hit_rs1[k] = ID_rs1_used & vld_q[k] & (rd_q[k] == ID_rs1);
         hit_rs2[k] = ID_rs2_used & vld_q[k] & (rd_q[k] == ID_rs2);
      end
      hit = hit_rs1 | hit_rs2;
   end

   // Decode stall/flush; a flush squashes ID anyway, so it overrides the stall.
   always_comb begin
      flush = branch_prediction_miss | EX_jump;
      if (FWD_EN) begin
         raw = ID_valid & hit[0] & ld_q[0];
      end else begin
         raw = ID_valid & (|hit);
      end
      hazard_op   = raw & ~flush;
      IF_ID_flush = flush;
      ID_EX_flush = flush | raw;
      issue       = ID_valid & ~hazard_op & ~flush;
   end

   // Next scoreboard contents: new entry (or bubble) at EX, everything else ages.
   always_comb begin
      vld_d    = '0;
      ld_d     = '0;
      vld_d[0] = issue & ID_rd_write & (ID_rd != '0);
      ld_d[0]  = issue & ID_rd_write & (ID_rd != '0) & ID_is_load;
      rd_d[0]  = ID_rd;
      for (int k = 1; k < TRACK_DEPTH; k++) begin
         vld_d[k] = vld_q[k-1];
         ld_d[k]  = ld_q[k-1];
         rd_d[k]  = rd_q[k-1];
      end
   end

   // Next counter values, one count per qualifying cycle.
   always_comb begin
      stall_cnt_d = hazard_op   ? sat_inc(stall_cnt_q) : stall_cnt_q;
      flush_cnt_d = IF_ID_flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
   end

   // Slot valid/load flags; reset empties the scoreboard immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q <= '0;
         ld_q  <= '0;
      end else begin
         vld_q <= vld_d;
         ld_q  <= ld_d;
      end
   end

   // Slot register indices; only meaningful while the matching valid is set.
   always_ff @(posedge clk) begin
      for (int k = 0; k < TRACK_DEPTH; k++) begin
         rd_q[k] <= rd_d[k];
      end
   end

   // Performance event counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: three instances (default, forwarding,
// 2-bit counters) share one directed stimulus stream and are checked every
// cycle against an issue-log model, plus hand-computed literal expectations.
module tb_hazard_scoreboard;
   localparam int DEPTH = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       ID_valid, rs1_used, rs2_used, rd_write, is_load, bpm, exj;
   logic [4:0] rs1, rs2, rd;

   logic        hz0, hz1, hz2, ifid0, ifid1, ifid2, idex0, idex1, idex2;
   logic [15:0] sc0, fc0, sc1, fc1;
   logic [1:0]  sc2, fc2;

   hazard_scoreboard u0 (
      .clk(clk), .reset(reset), .ID_valid(ID_valid), .ID_rs1(rs1), .ID_rs2(rs2),
      .ID_rs1_used(rs1_used), .ID_rs2_used(rs2_used), .ID_rd(rd), .ID_rd_write(rd_write),
      .ID_is_load(is_load), .branch_prediction_miss(bpm), .EX_jump(exj),
      .hazard_op(hz0), .IF_ID_flush(ifid0), .ID_EX_flush(idex0),
      .stall_count(sc0), .flush_count(fc0));

   hazard_scoreboard #(.FORWARDING(1)) u1 (
      .clk(clk), .reset(reset), .ID_valid(ID_valid), .ID_rs1(rs1), .ID_rs2(rs2),
      .ID_rs1_used(rs1_used), .ID_rs2_used(rs2_used), .ID_rd(rd), .ID_rd_write(rd_write),
      .ID_is_load(is_load), .branch_prediction_miss(bpm), .EX_jump(exj),
      .hazard_op(hz1), .IF_ID_flush(ifid1), .ID_EX_flush(idex1),
      .stall_count(sc1), .flush_count(fc1));

   hazard_scoreboard #(.CNT_WIDTH(2)) u2 (
      .clk(clk), .reset(reset), .ID_valid(ID_valid), .ID_rs1(rs1), .ID_rs2(rs2),
      .ID_rs1_used(rs1_used), .ID_rs2_used(rs2_used), .ID_rd(rd), .ID_rd_write(rd_write),
      .ID_is_load(is_load), .branch_prediction_miss(bpm), .EX_jump(exj),
      .hazard_op(hz2), .IF_ID_flush(ifid2), .ID_EX_flush(idex2),
      .stall_count(sc2), .flush_count(fc2));

   // Model: a log of issued register writers, each tagged with its age in
   // cycles since leaving ID (age 1 = in EX). Writers older than DEPTH are gone.
   typedef struct {
      int inst;
      int rd;
      bit ld;
      int age;
   } rec_t;

   rec_t pipe[$];
   int   m_sc[3];
   int   m_fc[3];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic int cnt_max(int inst);
      return (inst == 2) ? 3 : 65535;
   endfunction

   function automatic bit exp_raw(int inst);
      bit r;
      r = 1'b0;
      if (ID_valid !== 1'b1) return 1'b0;
      foreach (pipe[i]) begin
         if (pipe[i].inst == inst && pipe[i].age <= DEPTH &&
             ((rs1_used && pipe[i].rd == int'(rs1)) || (rs2_used && pipe[i].rd == int'(rs2)))) begin
            if (inst == 1) begin
               if (pipe[i].age == 1 && pipe[i].ld) r = 1'b1;
            end else begin
               r = 1'b1;
            end
         end
      end
      return r;
   endfunction

   function automatic int act_hz(int i);
      case (i)
         0: return int'(hz0);
         1: return int'(hz1);
         default: return int'(hz2);
      endcase
   endfunction
   function automatic int act_ifid(int i);
      case (i)
         0: return int'(ifid0);
         1: return int'(ifid1);
         default: return int'(ifid2);
      endcase
   endfunction
   function automatic int act_idex(int i);
      case (i)
         0: return int'(idex0);
         1: return int'(idex1);
         default: return int'(idex2);
      endcase
   endfunction
   function automatic int act_sc(int i);
      case (i)
         0: return int'(sc0);
         1: return int'(sc1);
         default: return int'(sc2);
      endcase
   endfunction
   function automatic int act_fc(int i);
      case (i)
         0: return int'(fc0);
         1: return int'(fc1);
         default: return int'(fc2);
      endcase
   endfunction

   task automatic check(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare process: check all three instances at every falling edge, then
   // advance the model by the rising edge that follows.
   initial begin
      rec_t r;
      rec_t nq[$];
      bit   fl;
      bit   hz_e[3];
      bit   raw_e;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            pipe.delete();
            m_sc = '{0, 0, 0};
            m_fc = '{0, 0, 0};
         end
         fl = (bpm === 1'b1) || (exj === 1'b1);
         for (int i = 0; i < 3; i++) begin
            raw_e   = exp_raw(i);
            hz_e[i] = raw_e & ~fl;
            check($sformatf("hazard_op[u%0d]", i), act_hz(i), int'(hz_e[i]));
            check($sformatf("IF_ID_flush[u%0d]", i), act_ifid(i), int'(fl));
            check($sformatf("ID_EX_flush[u%0d]", i), act_idex(i), int'(fl | raw_e));
            check($sformatf("stall_count[u%0d]", i), act_sc(i), m_sc[i]);
            check($sformatf("flush_count[u%0d]", i), act_fc(i), m_fc[i]);
         end
         if (reset === 1'b1) begin
            nq.delete();
            foreach (pipe[j]) begin
               if (pipe[j].age < DEPTH) begin
                  r = pipe[j];
                  r.age = r.age + 1;
                  nq.push_back(r);
               end
            end
            pipe = nq;
            for (int i = 0; i < 3; i++) begin
               if (ID_valid && !hz_e[i] && !fl && rd_write && rd != 5'd0) begin
                  r.inst = i;
                  r.rd   = int'(rd);
                  r.ld   = is_load;
                  r.age  = 1;
                  pipe.push_back(r);
               end
               if (hz_e[i] && m_sc[i] < cnt_max(i)) m_sc[i]++;
               if (fl && m_fc[i] < cnt_max(i)) m_fc[i]++;
            end
         end
      end
   end

   task automatic idle();
      ID_valid = 0; rs1_used = 0; rs2_used = 0; rd_write = 0; is_load = 0;
      bpm = 0; exj = 0; rs1 = '0; rs2 = '0; rd = '0;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int d, input int s1, input bit u1, input int s2,
                        input bit u2, input bit wr, input bit ld);
      ID_valid = 1; rd = 5'(d); rs1 = 5'(s1); rs1_used = u1; rs2 = 5'(s2);
      rs2_used = u2; rd_write = wr; is_load = ld; bpm = 0; exj = 0;
   endtask

   task automatic do_reset();
      reset = 0;
      idle();
      next();
      next();
      reset = 1;
   endtask

   // Producer x3 then consumer reading x3 held until u0 releases it.
   task automatic stall_pair(output int cyc);
      issue(3, 0, 0, 0, 0, 1, 0);
      next();
      issue(4, 3, 1, 0, 0, 0, 0);
      cyc = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!hz0) break;
         cyc++;
         next();
      end
      next();
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   int cnt;

   initial begin
      reset = 0;
      idle();
      // Reset held with arbitrary activity on the inputs.
      #1;
      issue(5, 5, 1, 3, 1, 1, 1);
      bpm = 1;
      @(negedge clk);
      check("reset hazard_op", int'(hz0), 0);
      check("reset stall_count", int'(sc0), 0);
      next();
      issue(6, 6, 1, 0, 0, 1, 0);
      exj = 1;
      @(negedge clk);
      check("reset flush_count", int'(fc0), 0);
      next();
      reset = 1;
      idle();
      next();
      issue(3, 1, 1, 2, 1, 1, 0);
      @(negedge clk);
      check("x1/x2->x3 no hazard", int'(hz0), 0);
      next();
      idle();
      next(); next(); next();

      // Back-to-back dependency, no forwarding: three stall cycles.
      do_reset();
      stall_pair(cnt);
      check("no-fwd stall cycles", cnt, 3);
      @(negedge clk);
      check("no-fwd stall_count u0", int'(sc0), 3);
      check("fwd ALU stall_count u1", int'(sc1), 0);
      next(); next(); next();

      // Unused rs2 and x0 never create a hazard.
      do_reset();
      issue(5, 0, 0, 0, 0, 1, 0);
      next();
      issue(8, 9, 1, 5, 0, 0, 0);
      @(negedge clk);
      check("rs2 unused no hazard", int'(hz0), 0);
      next();
      issue(0, 0, 0, 0, 0, 1, 0);
      next();
      issue(8, 0, 1, 0, 1, 0, 0);
      @(negedge clk);
      check("x0 no hazard", int'(hz0), 0);
      next();
      idle();
      next(); next(); next();

      // Forwarding: load-use stalls once, ALU producer never.
      do_reset();
      issue(7, 0, 0, 0, 0, 1, 1);
      next();
      issue(8, 7, 1, 0, 0, 0, 0);
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (hz1) cnt++;
         if (!hz0) break;
         next();
      end
      check("fwd load-use stall cycles", cnt, 1);
      check("fwd load-use stall_count u1", int'(sc1), 1);
      next();
      idle();
      next(); next(); next();

      do_reset();
      issue(7, 0, 0, 0, 0, 1, 0);
      next();
      issue(8, 7, 1, 0, 0, 0, 0);
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (hz1) cnt++;
         if (!hz0) break;
         next();
      end
      check("fwd ALU stall cycles", cnt, 0);
      next();
      idle();
      next(); next(); next();

      // Stall and flush together, then jump, then both sources at once.
      do_reset();
      issue(3, 0, 0, 0, 0, 1, 0);
      next();
      issue(4, 3, 1, 0, 0, 0, 0);
      bpm = 1;
      @(negedge clk);
      check("stall+miss hazard_op", int'(hz0), 0);
      check("stall+miss IF_ID_flush", int'(ifid0), 1);
      check("stall+miss ID_EX_flush", int'(idex0), 1);
      next();
      bpm = 0;
      exj = 1;
      @(negedge clk);
      check("flush_count after miss", int'(fc0), 1);
      next();
      bpm = 1;
      exj = 1;
      @(negedge clk);
      check("flush_count after jump", int'(fc0), 2);
      next();
      idle();
      @(negedge clk);
      check("flush_count both sources once", int'(fc0), 3);
      check("stall_count during flushes", int'(sc0), 0);
      next(); next(); next();

      // Counter saturation on the 2-bit instance, then reset mid-stall.
      do_reset();
      stall_pair(cnt);
      stall_pair(cnt);
      @(negedge clk);
      check("sat stall_count u2", int'(sc2), 3);
      check("unsat stall_count u0", int'(sc0), 6);
      next();
      issue(3, 0, 0, 0, 0, 1, 0);
      next();
      issue(4, 3, 1, 0, 0, 0, 0);
      @(negedge clk);
      check("mid-stall hazard_op before reset", int'(hz0), 1);
      next();
      reset = 0;
      @(negedge clk);
      check("reset mid-stall hazard_op", int'(hz0), 0);
      check("reset mid-stall stall_count u0", int'(sc0), 0);
      check("reset mid-stall stall_count u2", int'(sc2), 0);
      next();
      reset = 1;
      idle();
      next(); next(); next();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
